// File: rtl/posit16_to_fixed16_if.sv
// Valid/ready streams between a posit16 producer and the posit16-to-fixed16 decoder.
interface posit16_to_fixed16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] posit_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] fixed_out;
  logic        nar;
  logic        sat;
  logic [5:0]  scale;

  modport master (
    output in_valid, posit_in, out_ready,
    input  in_ready, out_valid, fixed_out, nar, sat, scale
  );

  modport slave (
    input  in_valid, posit_in, out_ready,
    output in_ready, out_valid, fixed_out, nar, sat, scale
  );
endinterface

// File: rtl/posit16_to_fixed16_seq.sv
// Sequential posit<16,1> to signed fixed-point decoder; regime run is scanned one bit per cycle.
module posit16_to_fixed16_seq #(
  parameter int unsigned FRAC_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  posit16_to_fixed16_if.slave  bus
);

  localparam int unsigned  MAG_W    = 15;
  localparam logic signed [7:0] SAT_LIM  = 8'(15 - FRAC_BITS);
  localparam logic signed [7:0] RSH_BASE = 8'(14 - FRAC_BITS);

  typedef enum logic [1:0] {IDLE, SCAN, ALIGN, DONE} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        fixed_q, fixed_d;
  logic               nar_q, nar_d;
  logic               sat_q, sat_d;
  logic [5:0]         scale_q, scale_d;
  logic               sign_q, sign_d;
  logic               r0_q, r0_d;
  logic [MAG_W-1:0]   sh_q, sh_d;
  logic [4:0]         run_q, run_d;
  logic [3:0]         left_q, left_d;

  logic [MAG_W-1:0]   mag_c;
  logic [5:0]         k_c;
  logic [5:0]         scale_c;
  logic signed [7:0]  sc8_c;
  logic               sat_c;
  logic [5:0]         rsh_c;
  logic [15:0]        mag_fx_c;
  logic [15:0]        fx_c;

  // Alignment datapath: 1.f * 2^(2k+e) into FRAC_BITS, truncated toward zero, then signed
  always_comb begin
    k_c      = r0_q ? (6'(run_q) - 6'd1) : (6'd0 - 6'(run_q));
    scale_c  = (k_c << 1) + {5'd0, sh_q[14]};
    sc8_c    = {{2{scale_c[5]}}, scale_c};
    sat_c    = (sc8_c >= SAT_LIM);
    rsh_c    = 6'(RSH_BASE - sc8_c);
    mag_fx_c = {2'b01, sh_q[13:0]} >> rsh_c;
    if (sat_c)
      fx_c = sign_q ? 16'h8001 : 16'h7FFF;
    else
      fx_c = sign_q ? (~mag_fx_c + 16'd1) : mag_fx_c;
  end

  always_comb begin
    state_d  = state_q;
    fixed_d  = fixed_q;
    nar_d    = nar_q;
    sat_d    = sat_q;
    scale_d  = scale_q;
    sign_d   = sign_q;
    r0_d     = r0_q;
    sh_d     = sh_q;
    run_d    = run_q;
    left_d   = left_q;
    mag_c    = bus.posit_in[15] ? (~bus.posit_in[14:0] + 15'd1) : bus.posit_in[14:0];

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          if (bus.posit_in == 16'h0000) begin
            fixed_d = 16'h0000;
            nar_d   = 1'b0;
            sat_d   = 1'b0;
            scale_d = 6'd0;
            state_d = DONE;
          end else if (bus.posit_in == 16'h8000) begin
            fixed_d = 16'h8000;
            nar_d   = 1'b1;
            sat_d   = 1'b0;
            scale_d = 6'd0;
            state_d = DONE;
          end else begin
            sign_d  = bus.posit_in[15];
            r0_d    = mag_c[14];
            sh_d    = mag_c;
            run_d   = 5'd0;
            left_d  = 4'(MAG_W);
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // Consume one regime bit; stop after the terminator or after bit 0
        sh_d   = {sh_q[13:0], 1'b0};
        left_d = left_q - 4'd1;
        if (sh_q[14] == r0_q) begin
          run_d = run_q + 5'd1;
          if (left_q == 4'd1) state_d = ALIGN;
        end else begin
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        fixed_d = fx_c;
        sat_d   = sat_c;
        scale_d = scale_c;
        nar_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_q == DONE) && !(out_valid_q && bus.out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      fixed_q     <= 16'h0000;
      nar_q       <= 1'b0;
      sat_q       <= 1'b0;
      scale_q     <= 6'd0;
      sign_q      <= 1'b0;
      r0_q        <= 1'b0;
      sh_q        <= '0;
      run_q       <= 5'd0;
      left_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      fixed_q     <= fixed_d;
      nar_q       <= nar_d;
      sat_q       <= sat_d;
      scale_q     <= scale_d;
      sign_q      <= sign_d;
      r0_q        <= r0_d;
      sh_q        <= sh_d;
      run_q       <= run_d;
      left_q      <= left_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fixed_out = fixed_q;
  assign bus.nar       = nar_q;
  assign bus.sat       = sat_q;
  assign bus.scale     = scale_q;

endmodule

// File: tb/tb_posit16_to_fixed16_seq.sv
// Directed bench for posit16_to_fixed16_seq with hand-computed Q4.12 expectations.
module tb_posit16_to_fixed16_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  posit16_to_fixed16_if bus ();

  posit16_to_fixed16_seq #(.FRAC_BITS(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word and check latency, result fields and the output handshake
  task automatic decode(input string tag, input logic [15:0] word, input logic [15:0] exp_fx,
                        input logic exp_nar, input logic exp_sat, input logic [5:0] exp_scale,
                        input int exp_lat, input int hold);
    int waited;
    int lat;
    waited = 0;
    while (!bus.in_ready && waited < 40) begin
      tick();
      waited++;
    end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.posit_in  = word;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_ready_drop"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.out_valid && lat < 40);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_fixed"}, 32'(bus.fixed_out), 32'(exp_fx));
    chk({tag, "_nar"}, 32'(bus.nar), 32'(exp_nar));
    chk({tag, "_sat"}, 32'(bus.sat), 32'(exp_sat));
    chk({tag, "_scale"}, 32'(bus.scale), 32'(exp_scale));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_fixed"}, 32'(bus.fixed_out), 32'(exp_fx));
      chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.posit_in  = 16'h0000;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_fixed", 32'(bus.fixed_out), 32'd0);
    chk("rst_flags", 32'({bus.nar, bus.sat, bus.scale}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    decode("p4000", 16'h4000, 16'h1000, 1'b0, 1'b0, 6'd0,  4,  0);
    decode("p4800", 16'h4800, 16'h1800, 1'b0, 1'b0, 6'd0,  4,  0);
    decode("p5000", 16'h5000, 16'h2000, 1'b0, 1'b0, 6'd1,  4,  0);
    decode("pC000", 16'hC000, 16'hF000, 1'b0, 1'b0, 6'd0,  4,  0);
    decode("p3000", 16'h3000, 16'h0800, 1'b0, 1'b0, 6'h3F, 4,  0);
    decode("p6000", 16'h6000, 16'h4000, 1'b0, 1'b0, 6'd2,  5,  0);
    decode("p7000", 16'h7000, 16'h7FFF, 1'b0, 1'b1, 6'd4,  6,  0);
    decode("p9000", 16'h9000, 16'h8001, 1'b0, 1'b1, 6'd4,  6,  0);
    decode("p7FFF", 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 6'd28, 17, 0);
    decode("p0001", 16'h0001, 16'h0000, 1'b0, 1'b0, 6'h24, 17, 0);
    decode("zero",  16'h0000, 16'h0000, 1'b0, 1'b0, 6'd0,  1,  0);
    decode("nar",   16'h8000, 16'h8000, 1'b1, 1'b0, 6'd0,  1,  0);

    decode("bp_c000", 16'hC000, 16'hF000, 1'b0, 1'b0, 6'd0, 4, 10);
    decode("b2b_5000", 16'h5000, 16'h2000, 1'b0, 1'b0, 6'd1, 4, 0);
    decode("b2b_6000", 16'h6000, 16'h4000, 1'b0, 1'b0, 6'd2, 5, 0);
    decode("b2b_9000", 16'h9000, 16'h8001, 1'b0, 1'b1, 6'd4, 6, 0);

    // Reset in the middle of scanning 0x0001: that word must never appear
    bus.posit_in = 16'h0001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_fixed", 32'(bus.fixed_out), 32'd0);
    chk("midrst_flags", 32'({bus.nar, bus.sat, bus.scale}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    decode("post_rst", 16'h4000, 16'h1000, 1'b0, 1'b0, 6'd0, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
